ps2_kbd_rx: RTL
===============

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8192: clk cycles without a ps2_clk_in falling edge before an open frame is abandoned.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, power of two.
REQ-003 SHALL have port clk, input, 1: single core clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk_in, input, 1: PS/2 clock, asynchronous to clk, idle high.
REQ-006 SHALL have port ps2_data_in, input, 1: PS/2 data, asynchronous to clk, idle high.
REQ-007 SHALL have port evt_valid, output, 1: FIFO head event present.
REQ-008 SHALL have port evt_ready, input, 1: consumer accepts the head event.
REQ-009 SHALL have port evt_code, output, 8: head event scancode.
REQ-010 SHALL have port evt_ext, output, 1: head event was preceded by 0xE0.
REQ-011 SHALL have port evt_release, output, 1: head event was preceded by 0xF0.
REQ-012 SHALL have port parity_err, output, 1: one-cycle pulse on a parity failure.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit or a timeout.
REQ-014 SHALL have port overflow, output, 1: one-cycle pulse when an event is dropped.
REQ-015 SHALL have port busy, output, 1: receiver state is not IDLE.

Function
REQ-016 SHALL pass both PS/2 inputs through two-flop synchronizers; falling edge = previous synced clock 1 and current 0.
REQ-017 SHALL run states IDLE, DATA, PARITY, STOP; every transition occurs only on a detected falling edge, except timeout.
REQ-018 IDLE: on a falling edge with data 0 (start bit), go to DATA with bit count 0; with data 1, stay in IDLE and report no error.
REQ-019 DATA: shift 8 bits LSB first; after the 8th bit, go to PARITY.
REQ-020 PARITY: latch the bit; parity is good when the XOR of the 8 data bits and the parity bit equals 1 (odd); then go to STOP.
REQ-021 STOP: stop bit 0 -> frame_err pulse; else bad parity -> parity_err pulse; else the byte is delivered; go to IDLE in every case.
REQ-022 In any state other than IDLE, a counter SHALL clear on each falling edge; when it reaches TIMEOUT_CYCLES, the receiver returns to IDLE and pulses frame_err.
REQ-023 A delivered byte 0xE0 SHALL set ext_pend and 0xF0 SHALL set rel_pend; neither pushes an event.
REQ-024 Any other delivered byte, including 0xE1, SHALL push {ext_pend, rel_pend, byte} and clear both pending flags.
REQ-025 Any parity_err or frame_err SHALL clear ext_pend and rel_pend.
REQ-026 evt_valid SHALL assert exactly 4 clk cycles after the stop-bit falling edge of ps2_clk_in.
REQ-027 The evt_* outputs SHALL reflect the FIFO head and stay stable while evt_valid=1 and evt_ready=0.
REQ-028 A pop occurs on a cycle with evt_valid=1 and evt_ready=1.
REQ-029 A push while the FIFO is full and no pop occurs SHALL drop the new event and pulse overflow; FIFO contents are unchanged.
REQ-030 A push and a pop in the same cycle with the FIFO full SHALL both occur, with no overflow.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-032 While reset_n=0: state IDLE, FIFO empty, pending flags clear, counters 0, synchronizer flops 1.
REQ-033 While reset_n=0: evt_valid, parity_err, frame_err, overflow and busy = 0; evt_code = 0x00; evt_ext and evt_release = 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; the first start bit after release begins a new frame.

Structure
REQ-035 Package ps2_pkg SHALL hold the rx state enum, PS2_EXT=8'hE0, PS2_REL=8'hF0, and the 10-bit event type.
REQ-036 The FIFO SHALL be sub-module ps2_evt_fifo (parameterised depth and width, push/pop/full/empty, overflow flag).

Verification
REQ-037 Frame 0x1C with parity 0 and stop 1 -> one event: code 0x1C, ext 0, release 0; no error pulses.
REQ-038 Frames E0, F0, 74 -> exactly one event: code 0x74, ext 1, release 1.
REQ-039 Frame 0x1C with parity 1 -> parity_err pulse, no event; the next frame 0x32 yields an event with ext 0 and release 0.
REQ-040 Start bit plus 5 data bits, then 8300 idle cycles -> frame_err pulse and busy=0; a following 0x29 frame is received correctly.
REQ-041 Six frames 0x01 to 0x06 with evt_ready=0 -> events 01 to 04 held in order; overflow pulses twice; draining yields 01, 02, 03, 04 then evt_valid=0.
REQ-042 reset_n pulsed low during DATA bit 4 -> no event and no error; the next 0x5A frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and its event FIFO.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int EVT_W = $bits(ps2_evt_t);

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small synchronous FIFO for decoded key events; drops pushes when full and flags them.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    // DEPTH must be a power of two, at least 2; the extra MSB tells full from empty.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot this cycle, so a push into a full FIFO still fits.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = push & full & ~do_pop;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow  = overflow_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the bus, frames bytes, folds E0/F0 prefixes into events.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int              TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
    logic ps2_dat_s1_q, ps2_dat_s2_q;
    logic fall;

    rx_state_e        state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [TMO_W-1:0] tmo_q;
    logic             byte_done_q, parity_err_q, frame_err_q;

    logic     ext_pend_q, ext_pend_d;
    logic     rel_pend_q, rel_pend_d;
    logic     push, pop, fifo_full, fifo_empty;
    ps2_evt_t push_evt, head_evt;

    // Both lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_s1_q <= 1'b1;
            ps2_clk_s2_q <= 1'b1;
            ps2_clk_s3_q <= 1'b1;
            ps2_dat_s1_q <= 1'b1;
            ps2_dat_s2_q <= 1'b1;
        end else begin
            ps2_clk_s1_q <= ps2_clk_in;
            ps2_clk_s2_q <= ps2_clk_s1_q;
            ps2_clk_s3_q <= ps2_clk_s2_q;
            ps2_dat_s1_q <= ps2_data_in;
            ps2_dat_s2_q <= ps2_dat_s1_q;
        end
    end

    assign fall = ps2_clk_s3_q & ~ps2_clk_s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            byte_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (state_q == ST_IDLE || fall) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_MAX) begin
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
                tmo_q       <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (fall) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!ps2_dat_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {ps2_dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= ps2_dat_s2_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!ps2_dat_s2_q)                      frame_err_q  <= 1'b1;
                        else if (!odd_parity_ok(shift_q, par_q)) parity_err_q <= 1'b1;
                        else                                     byte_done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // shift_q holds the delivered byte until the next frame's first data edge, far later.
    always_comb begin
        ext_pend_d = ext_pend_q;
        rel_pend_d = rel_pend_q;
        push       = 1'b0;
        if (parity_err_q || frame_err_q) begin
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
        end else if (byte_done_q) begin
            if (shift_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PS2_REL) begin
                rel_pend_d = 1'b1;
            end else begin
                push       = 1'b1;
                ext_pend_d = 1'b0;
                rel_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            rel_pend_q <= rel_pend_d;
        end
    end

    assign push_evt = '{ext: ext_pend_q, rel: rel_pend_q, code: shift_q};
    assign pop      = evt_valid & evt_ready;

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .head_data (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign evt_valid   = ~fifo_empty;
    assign evt_code    = head_evt.code;
    assign evt_ext     = head_evt.ext;
    assign evt_release = head_evt.rel;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
